// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared op encoding, default vectors and sizing helper for the program counter stack
package pc_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_BRANCH,
        OP_LOAD,
        OP_CALL,
        OP_RET
    } op_t;

    localparam int DEFAULT_WIDTH        = 16;
    localparam int DEFAULT_OFFSET_W     = 8;
    localparam int DEFAULT_STACK_DEPTH  = 8;
    localparam int DEFAULT_RESET_VECTOR = 0;

    // Level counter must represent 0..depth inclusive
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// rtl/pc_ret_stack.sv - return-address LIFO with level, full and empty status
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH,
    localparam int LW         = level_w(STACK_DEPTH),
    localparam int PW         = $clog2(STACK_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [STACK_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Level doubles as the write pointer; the top entry sits one below it
    assign wr_ptr   = level[PW-1:0];
    assign rd_ptr   = wr_ptr - PW'(1);
    assign top_data = mem[rd_ptr];
    assign full     = (level == LW'(STACK_DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty && !push;

    // Storage needs no reset: entries above the level are never read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Entry count, guarded so it never leaves 0..STACK_DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= '0;
        end else if (do_push) begin
            level <= level + LW'(1);
        end else if (do_pop) begin
            level <= level - LW'(1);
        end
    end

endmodule

// File: rtl/program_counter_stack.sv
// rtl/program_counter_stack.sv - program counter with relative branch, call/return stack and sticky errors (option: PC_STACK_TRAP_EN)
module program_counter_stack
    import pc_pkg::*;
#(
    parameter int               WIDTH        = DEFAULT_WIDTH,
    parameter int               OFFSET_W     = DEFAULT_OFFSET_W,
    parameter int               STACK_DEPTH  = DEFAULT_STACK_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = {WIDTH{1'b1}},
    localparam int              LW           = level_w(STACK_DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                halt,
    input  logic                inc,
    input  logic                load,
    input  logic                branch,
    input  logic                call,
    input  logic                ret,
    input  logic                err_clr,
    input  logic [WIDTH-1:0]    data_in,
    input  logic [OFFSET_W-1:0] offset,
    output logic [WIDTH-1:0]    pc_out,
    output logic [LW-1:0]       stack_level,
    output logic                stack_full,
    output logic                stack_empty,
    output logic                ovf_err,
    output logic                unf_err
);

    op_t                     op;
    logic [WIDTH-1:0]        pc;
    logic [WIDTH-1:0]        pc_next;
    logic [WIDTH-1:0]        pc_plus1;
    logic signed [WIDTH-1:0] offset_ext;
    logic [WIDTH-1:0]        err_pc;
    logic [WIDTH-1:0]        top_data;
    logic                    call_ovf;
    logic                    ret_unf;

    assign pc_plus1   = pc + WIDTH'(1);
    assign offset_ext = WIDTH'($signed(offset));
    assign call_ovf   = (op == OP_CALL) && stack_full;
    assign ret_unf    = (op == OP_RET) && stack_empty;

`ifdef PC_STACK_TRAP_EN
    assign err_pc = TRAP_VECTOR;
`else
    logic unused_trap;
    assign unused_trap = ^TRAP_VECTOR;
    assign err_pc      = pc;
`endif

    // Priority encoder: halt masks every op, then ret > call > load > branch > inc
    always_comb begin
        op = OP_HOLD;
        if (!halt) begin
            if (ret)         op = OP_RET;
            else if (call)   op = OP_CALL;
            else if (load)   op = OP_LOAD;
            else if (branch) op = OP_BRANCH;
            else if (inc)    op = OP_INC;
        end
    end

    // Next-PC mux; stack errors either hold or trap depending on build
    always_comb begin
        pc_next = pc;
        case (op)
            OP_INC:    pc_next = pc_plus1;
            OP_BRANCH: pc_next = pc + offset_ext;
            OP_LOAD:   pc_next = data_in;
            OP_CALL:   pc_next = stack_full  ? err_pc : data_in;
            OP_RET:    pc_next = stack_empty ? err_pc : top_data;
            default:   pc_next = pc;
        endcase
    end

    // PC register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_VECTOR;
        end else begin
            pc <= pc_next;
        end
    end

    // Sticky error flags; a fresh error wins over a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            ovf_err <= (ovf_err && !err_clr) || call_ovf;
            unf_err <= (unf_err && !err_clr) || ret_unf;
        end
    end

    pc_ret_stack #(
        .WIDTH       (WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (op == OP_CALL),
        .pop       (op == OP_RET),
        .push_data (pc_plus1),
        .top_data  (top_data),
        .level     (stack_level),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    assign pc_out = pc;

endmodule

// File: tb/tb_program_counter_stack.sv
// tb/tb_program_counter_stack.sv - randomized self-checking bench for program_counter_stack against a queue model
module tb_program_counter_stack;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        halt = 1'b0;
    logic        inc = 1'b0;
    logic        load = 1'b0;
    logic        branch = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] data_in = '0;
    logic [7:0]  offset = '0;
    logic [15:0] pc_out;
    logic [3:0]  stack_level;
    logic        stack_full;
    logic        stack_empty;
    logic        ovf_err;
    logic        unf_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_pc;
    int m_stk[$];
    bit m_ovf;
    bit m_unf;

    program_counter_stack #(
        .WIDTH        (16),
        .OFFSET_W     (8),
        .STACK_DEPTH  (8),
        .RESET_VECTOR (16'h0000),
        .TRAP_VECTOR  (16'hFFFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .halt        (halt),
        .inc         (inc),
        .load        (load),
        .branch      (branch),
        .call        (call),
        .ret         (ret),
        .err_clr     (err_clr),
        .data_in     (data_in),
        .offset      (offset),
        .pc_out      (pc_out),
        .stack_level (stack_level),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int trap_or_hold(input int cur);
`ifdef PC_STACK_TRAP_EN
        return 16'hFFFF;
`else
        return cur;
`endif
    endfunction

    task automatic model_reset();
        m_pc = 0;
        m_stk.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic model_step(input bit h, i, l, b, c, r, ec, input int d, input logic [7:0] o);
        int off;
        off = $signed(o);
        if (ec) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (h) return;
        if (r) begin
            if (m_stk.size() == 0) begin
                m_unf = 1;
                m_pc  = trap_or_hold(m_pc);
            end else begin
                m_pc = m_stk.pop_back();
            end
        end else if (c) begin
            if (m_stk.size() == 8) begin
                m_ovf = 1;
                m_pc  = trap_or_hold(m_pc);
            end else begin
                m_stk.push_back((m_pc + 1) & 16'hFFFF);
                m_pc = d;
            end
        end else if (l) begin
            m_pc = d;
        end else if (b) begin
            m_pc = (m_pc + off) & 16'hFFFF;
        end else if (i) begin
            m_pc = (m_pc + 1) & 16'hFFFF;
        end
    endtask

    task automatic check_all(input string tag);
        int lvl;
        lvl = m_stk.size();
        check({tag, ".pc"},    32'(pc_out),      32'(m_pc));
        check({tag, ".level"}, 32'(stack_level), 32'(lvl));
        check({tag, ".full"},  32'(stack_full),  32'(lvl == 8));
        check({tag, ".empty"}, 32'(stack_empty), 32'(lvl == 0));
        check({tag, ".ovf"},   32'(ovf_err),     32'(m_ovf));
        check({tag, ".unf"},   32'(unf_err),     32'(m_unf));
    endtask

    // One clock with the given strobes; inputs driven mid-cycle, outputs sampled 1 after the edge
    task automatic cycle(input string tag, input bit h, i, l, b, c, r, ec,
                         input logic [15:0] d, input logic [7:0] o);
        halt = h; inc = i; load = l; branch = b; call = c; ret = r; err_clr = ec;
        data_in = d; offset = o;
        @(posedge clk);
        model_step(h, i, l, b, c, r, ec, int'(d), o);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset asserted between edges, checked before any clock
    task automatic async_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        check_all("por");
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Wrap on inc and negative branch
        cycle("ld_fffe", 0,0,1,0,0,0,0, 16'hFFFE, 8'h00);
        cycle("inc1",    0,1,0,0,0,0,0, 16'h0000, 8'h00);
        check("inc_ffff", 32'(pc_out), 32'h0000FFFF);
        cycle("inc2",    0,1,0,0,0,0,0, 16'h0000, 8'h00);
        check("inc_wrap", 32'(pc_out), 32'h00000000);
        cycle("inc3",    0,1,0,0,0,0,0, 16'h0000, 8'h00);
        check("inc_0001", 32'(pc_out), 32'h00000001);
        cycle("ld_0010", 0,0,1,0,0,0,0, 16'h0010, 8'h00);
        cycle("br_neg",  0,0,0,1,0,0,0, 16'h0000, 8'hF0);
        check("br_neg_val", 32'(pc_out), 32'h00000000);

        // Single call / return
        cycle("ld_0100", 0,0,1,0,0,0,0, 16'h0100, 8'h00);
        cycle("call1",   0,0,0,0,1,0,0, 16'h2000, 8'h00);
        check("call1_pc", 32'(pc_out), 32'h00002000);
        check("call1_lv", 32'(stack_level), 32'd1);
        cycle("ret1",    0,0,0,0,0,1,0, 16'h0000, 8'h00);
        check("ret1_pc", 32'(pc_out), 32'h00000101);
        check("ret1_em", 32'(stack_empty), 32'd1);

        // Fill to depth, overflow, clear
        for (int k = 0; k < 8; k++)
            cycle("nest", 0,0,0,0,1,0,0, 16'(k * 16), 8'h00);
        check("nest_full", 32'(stack_full), 32'd1);
        cycle("ovf", 0,0,0,0,1,0,0, 16'h4444, 8'h00);
        check("ovf_flag", 32'(ovf_err), 32'd1);
`ifdef PC_STACK_TRAP_EN
        check("ovf_pc", 32'(pc_out), 32'h0000FFFF);
`else
        check("ovf_pc", 32'(pc_out), 32'h00000070);
`endif
        cycle("ovf_clr", 0,0,0,0,0,0,1, 16'h0000, 8'h00);
        check("ovf_clr_flag", 32'(ovf_err), 32'd0);

        // Mid-run async reset with pc=0x0123, level=3
        async_reset("rst_a");
        for (int k = 0; k < 3; k++)
            cycle("pre", 0,0,0,0,1,0,0, 16'h0300, 8'h00);
        cycle("ld_0123", 0,0,1,0,0,0,0, 16'h0123, 8'h00);
        async_reset("rst_mid");
        check("rst_mid_pc", 32'(pc_out), 32'h00000000);

        // Underflow and op priority
        cycle("ld_0055", 0,0,1,0,0,0,0, 16'h0055, 8'h00);
        cycle("unf",     0,0,0,0,0,1,0, 16'h0000, 8'h00);
        check("unf_flag", 32'(unf_err), 32'd1);
        cycle("call_p",  0,0,0,0,1,0,0, 16'h0600, 8'h00);
        cycle("prio",    0,1,0,0,1,1,0, 16'h0900, 8'h00);
        check("prio_lv", 32'(stack_level), 32'd0);

        // Halt freezes everything but err_clr; same-cycle clear and error keeps flag
        for (int k = 0; k < 5; k++)
            cycle("halt", 1,1,1,0,1,0,0, 16'h0AAA, 8'h00);
        cycle("halt_clr", 1,1,0,0,0,0,1, 16'h0000, 8'h00);
        check("halt_clr_unf", 32'(unf_err), 32'd0);
        cycle("clr_new", 0,0,0,0,0,1,1, 16'h0000, 8'h00);
        check("clr_new_unf", 32'(unf_err), 32'd1);

        // Randomized mix
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rnd_rst");
            end else begin
                cycle("rnd",
                      $urandom_range(0, 9) == 0,
                      $urandom_range(0, 2) == 0,
                      $urandom_range(0, 5) == 0,
                      $urandom_range(0, 4) == 0,
                      $urandom_range(0, 3) == 0,
                      $urandom_range(0, 3) == 0,
                      $urandom_range(0, 9) == 0,
                      16'($urandom), 8'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
